spi_sram_port: RTL and testbench



---
 rtl/spi_sram_pkg.sv | 12 +
 rtl/spi_sram_port.sv | 124 ++++++++++++
 tb/tb_spi_sram_port.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_pkg.sv
// Shared constants for the serial SRAM port: command opcodes and frame sizing.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    function automatic int unsigned frame_len(input int unsigned addr_bits,
                                              input int unsigned data_bytes);
        return 8 + addr_bits + 8 * data_bytes;
    endfunction

endpackage

// File: rtl/spi_sram_port.sv
// SPI mode-0 master that runs one command/address/data frame against a serial SRAM
// per read or write strobe; read data is returned little-endian.
module spi_sram_port
    import spi_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_BYTES = 2,
    parameter int unsigned ADDR_BITS        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_BITS-1:0]          addr_in,
    input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
    input  logic                          start_read,
    input  logic                          start_write,
    output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
    output logic                          busy,
    output logic                          spi_select,
    output logic                          spi_clk_out,
    output logic                          spi_mosi,
    input  logic                          spi_miso
);

    localparam int unsigned FrameLen  = frame_len(ADDR_BITS, DATA_WIDTH_BYTES);
    localparam int unsigned DataWidth = 8 * DATA_WIDTH_BYTES;
    localparam int unsigned CntW      = $clog2(FrameLen + 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 phase_q, phase_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [FrameLen-1:0]  tx_q, tx_d;
    logic [DataWidth-1:0] rx_q, rx_d;
    logic [DataWidth-1:0] data_out_q, data_out_d;
    logic                 is_read_q, is_read_d;
    logic                 mosi_q, mosi_d;

    // Byte 0 travels first on the wire, so it must sit in the most significant slot.
    function automatic logic [DataWidth-1:0] swap_bytes(input logic [DataWidth-1:0] v);
        logic [DataWidth-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_WIDTH_BYTES); i++) begin
            r[8*i +: 8] = v[8*(int'(DATA_WIDTH_BYTES)-1-i) +: 8];
        end
        return r;
    endfunction

    always_comb begin
        logic [7:0] cmd;
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        is_read_d  = is_read_q;
        mosi_d     = mosi_q;
        cmd        = start_read ? CMD_READ : CMD_WRITE;

        unique case (state_q)
            StIdle: begin
                if (start_read || start_write) begin
                    state_d   = StShift;
                    phase_d   = 1'b0;
                    cnt_d     = '0;
                    is_read_d = start_read;
                    tx_d      = {cmd, addr_in, start_read ? '0 : swap_bytes(data_in)};
                    mosi_d    = cmd[7];
                end
            end
            StShift: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // End of phase 1: sclk falls, MISO is sampled, next bit goes out.
                    phase_d = 1'b0;
                    rx_d    = {rx_q[DataWidth-2:0], spi_miso};
                    tx_d    = {tx_q[FrameLen-2:0], 1'b0};
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(FrameLen - 1)) begin
                        state_d = StIdle;
                        mosi_d  = 1'b0;
                        if (is_read_q) begin
                            data_out_d = swap_bytes(rx_d);
                        end
                    end else begin
                        mosi_d = tx_q[FrameLen-2];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            is_read_q  <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            is_read_q  <= is_read_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy        = (state_q == StShift);
    assign spi_select  = (state_q == StIdle);
    assign spi_clk_out = phase_q;
    assign spi_mosi    = mosi_q;
    assign data_out    = data_out_q;

endmodule

// File: tb/tb_spi_sram_port.sv
// Bench for spi_sram_port: behavioural serial SRAM on the wire plus a byte-array
// reference memory; directed and random transactions.
module tb_spi_sram_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic        start_read;
    logic        start_write;
    logic [15:0] data_out;
    logic        busy;
    logic        spi_select;
    logic        spi_clk_out;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_sram_port dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .start_read  (start_read),
        .start_write (start_write),
        .data_out    (data_out),
        .busy        (busy),
        .spi_select  (spi_select),
        .spi_clk_out (spi_clk_out),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    // Serial SRAM slave and the reference memory it should agree with
    logic [7:0]  sram    [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [39:0] frame_sh = '0;
    int          nbits = 0;
    int          sclk_rises = 0;
    logic [7:0]  s_cmd = '0;
    logic [15:0] s_addr = '0;
    logic [39:0] frames [$];
    int          flens  [$];
    logic [15:0] last_read = '0;

    always @(negedge spi_select) begin
        nbits    = 0;
        frame_sh = '0;
        s_cmd    = '0;
    end

    always @(posedge spi_select) begin
        logic [15:0] wa;
        if (nbits > 0) begin
            frames.push_back(frame_sh);
            flens.push_back(nbits);
            if (nbits == 40 && frame_sh[39:32] == 8'h02) begin
                wa       = frame_sh[31:16];
                sram[wa] = frame_sh[15:8];
                wa       = wa + 16'd1;
                sram[wa] = frame_sh[7:0];
            end
            nbits = 0;
        end
    end

    always @(posedge spi_clk_out) begin
        int k;
        logic [15:0] ba;
        logic [7:0]  bv;
        sclk_rises++;
        if (nbits >= 24 && nbits < 40 && s_cmd == 8'h03) begin
            k        = nbits - 24;
            ba       = s_addr + 16'(k / 8);
            bv       = sram[ba];
            spi_miso = bv[7 - (k % 8)];
        end else begin
            spi_miso = 1'($urandom);
        end
        frame_sh = {frame_sh[38:0], spi_mosi};
        nbits++;
        if (nbits == 24) begin
            s_cmd  = frame_sh[23:16];
            s_addr = frame_sh[15:0];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input bit restrobe);
        logic [7:0]  cmd;
        logic [39:0] exp_frame;
        logic [15:0] a1;
        int          cyc;
        bit          glitch;
        cmd       = rd ? 8'h03 : 8'h02;
        exp_frame = {cmd, a, rd ? 16'h0000 : {d[7:0], d[15:8]}};
        a1        = a + 16'd1;
        frames.delete();
        flens.delete();
        sclk_rises = 0;

        @(negedge clk);
        addr_in = a; data_in = d; start_read = rd; start_write = wr;
        @(negedge clk);
        start_read = 1'b0; start_write = 1'b0;
        addr_in = 16'($urandom); data_in = 16'($urandom);
        check("start_busy", 64'(busy), 64'd1);
        check("start_select", 64'(spi_select), 64'd0);
        check("start_sclk", 64'(spi_clk_out), 64'd0);
        check("start_mosi", 64'(spi_mosi), 64'(cmd[7]));

        cyc = 1;
        glitch = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (restrobe && cyc == 30) begin
                start_read = 1'b1; start_write = 1'b1;
            end else begin
                start_read = 1'b0; start_write = 1'b0;
            end
            @(negedge clk);
            if (busy === 1'b1) begin
                cyc++;
                if (spi_select !== 1'b0) glitch = 1;
            end
        end
        start_read = 1'b0; start_write = 1'b0;

        if (rd) begin
            last_read = {ref_mem[a1], ref_mem[a]};
        end else begin
            ref_mem[a]  = d[7:0];
            ref_mem[a1] = d[15:8];
        end
        check("busy_cycles", 64'(cyc), 64'd80);
        check("end_select", 64'(spi_select), 64'd1);
        check("end_mosi", 64'(spi_mosi), 64'd0);
        check("end_sclk", 64'(spi_clk_out), 64'd0);
        check("data_out", 64'(data_out), 64'(last_read));
        check("select_glitch", 64'(glitch), 64'd0);
        check("sclk_rises", 64'(sclk_rises), 64'd40);

        repeat (3) @(negedge clk);
        check("idle_after", 64'(busy), 64'd0);
        check("frame_count", 64'(frames.size()), 64'd1);
        if (frames.size() > 0) begin
            check("frame_bits", 64'(frames[0]), 64'(exp_frame));
            check("frame_len", 64'(flens[0]), 64'd40);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        rst_n = 1'b0; start_read = 1'b1; start_write = 1'b1;
        addr_in = 16'h5555; data_in = 16'hAAAA;

        // Reset with strobes held high
        repeat (4) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_select", 64'(spi_select), 64'd1);
        check("rst_sclk", 64'(spi_clk_out), 64'd0);
        check("rst_mosi", 64'(spi_mosi), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        rst_n = 1'b1; start_read = 1'b0; start_write = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        check("post_rst_frames", 64'(frames.size()), 64'd0);

        // Directed write, read, both-strobes, restrobe while busy
        run_txn(1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
        sram[16'h0010] = 8'hAD; ref_mem[16'h0010] = 8'hAD;
        sram[16'h0011] = 8'hDE; ref_mem[16'h0011] = 8'hDE;
        run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        check("read_dead", 64'(data_out), 64'hDEAD);
        run_txn(1'b1, 1'b1, 16'h1234, 16'h7777, 1'b0);
        check("both_read", 64'(data_out), 64'hBEEF);
        run_txn(1'b0, 1'b1, 16'h2000, 16'hC0DE, 1'b1);
        run_txn(1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1);

        // Abort a read at bit 20
        @(negedge clk);
        addr_in = 16'h1234; start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_select", 64'(spi_select), 64'd1);
        check("abort_sclk", 64'(spi_clk_out), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_mosi", 64'(spi_mosi), 64'd0);
        check("abort_data_out", 64'(data_out), 64'd0);
        rst_n = 1'b1;
        last_read = '0;
        run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

        // Random traffic in a small window that straddles the address wrap
        for (int t = 0; t < 12; t++) begin
            logic [15:0] ra;
            logic        rr;
            ra = 16'($urandom_range(0, 7)) - 16'd4;
            rr = 1'($urandom);
            run_txn(rr, ~rr | 1'($urandom), ra, 16'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
